hazard_scoreboard: RTL and testbench

- Tracks in-flight register writes in the EXE, MEM and WB stages of the ARM pipeline.
- Drives the stall request into IF/ID and generates the destination/write-enable tags that the forwarding selector consumes (Dest_MEM, Dest_WB, WB_EN_MEM, WB_EN_WB). It is the producer side of that interface.
- Decides when forwarding cannot cover a dependency: load-use, or forwarding disabled.
- Honours memory freeze and branch flush.

---
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard.sv | 87 ++++++++
 tb/tb_hazard_scoreboard.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: ID-stage request fields going into the scoreboard,
// and the stall request plus the MEM/WB forwarding tags coming back out.
//   master : ID stage side (drives the instruction fields and pipeline control)
//   slave  : scoreboard side (drives hazard, the MEM/WB tags and stall_count)
interface hazard_scoreboard_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             two_src;
  logic             id_wb_en;
  logic [REG_W-1:0] id_dest;
  logic             id_mem_r;
  logic             FW_en;
  logic             freeze;
  logic             flush;

  logic             hazard;
  logic [REG_W-1:0] Dest_MEM;
  logic             WB_EN_MEM;
  logic [REG_W-1:0] Dest_WB;
  logic             WB_EN_WB;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, src1, src2, two_src, id_wb_en, id_dest, id_mem_r,
           FW_en, freeze, flush,
    input  hazard, Dest_MEM, WB_EN_MEM, Dest_WB, WB_EN_WB, stall_count
  );

  modport slave (
    input  id_valid, src1, src2, two_src, id_wb_en, id_dest, id_mem_r,
           FW_en, freeze, flush,
    output hazard, Dest_MEM, WB_EN_MEM, Dest_WB, WB_EN_WB, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the ARM pipeline.
// Tracks in-flight register writes in EXE, MEM and WB, requests an IF/ID
// stall when forwarding cannot cover a dependency (load-use, or forwarding
// disabled), and produces the MEM/WB destination tags for the forwarding mux.
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : hazard_scoreboard_if slave (ID fields, FW_en/freeze/flush in;
//          hazard, Dest_MEM, WB_EN_MEM, Dest_WB, WB_EN_WB, stall_count out)
module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic             v;
    logic             wb_en;
    logic [REG_W-1:0] dest;
    logic             mem_r;
  } slot_t;

  slot_t            exe_q, mem_q, wb_q;
  slot_t            id_slot;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             raw;
  logic             hazard_int;
  logic             exe_src1, exe_src2, mem_src1, mem_src2;

  function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] r);
    return s.v & s.wb_en & (s.dest == r);
  endfunction

  assign exe_src1 = slot_match(exe_q, bus.src1);
  assign exe_src2 = slot_match(exe_q, bus.src2);
  assign mem_src1 = slot_match(mem_q, bus.src1);
  assign mem_src2 = slot_match(mem_q, bus.src2);

  // WB never stalls: the register file writes in the first half-cycle, so
  // ID reads the fresh value. With forwarding on, only a load still in EXE
  // is uncoverable because its data does not exist until the end of MEM.
  always_comb begin
    raw = 1'b0;
    if (bus.id_valid) begin
      if (bus.FW_en)
        raw = exe_q.mem_r & (exe_src1 | (bus.two_src & exe_src2));
      else
        raw = exe_src1 | mem_src1 | (bus.two_src & (exe_src2 | mem_src2));
    end
  end

  // A flushed ID instruction is dead, so it cannot need a stall.
  assign hazard_int = raw & ~bus.flush;

  // Write-enable and load flags are qualified by valid so a bubble in ID
  // can never leave a stale write tag in the pipeline.
  assign id_slot = {bus.id_valid,
                    bus.id_wb_en & bus.id_valid,
                    bus.id_dest,
                    bus.id_mem_r & bus.id_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q       <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else if (!bus.freeze) begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      exe_q <= (hazard_int || bus.flush) ? slot_t'('0) : id_slot;
      if (hazard_int && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.hazard      = hazard_int;
  assign bus.Dest_MEM    = mem_q.dest;
  assign bus.WB_EN_MEM   = mem_q.v & mem_q.wb_en;
  assign bus.Dest_WB     = wb_q.dest;
  assign bus.WB_EN_WB    = wb_q.v & wb_q.wb_en;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(4), .CNT_W(16)) bus ();
  hazard_scoreboard_if #(.REG_W(4), .CNT_W(6))  sat_bus ();

  hazard_scoreboard #(.REG_W(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter copy fed the same stimulus, so saturation is reachable
  // in a short run (a single producer can stall at most 2 of every 3 cycles).
  hazard_scoreboard #(.REG_W(4), .CNT_W(6)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  assign sat_bus.id_valid = bus.id_valid;
  assign sat_bus.src1     = bus.src1;
  assign sat_bus.src2     = bus.src2;
  assign sat_bus.two_src  = bus.two_src;
  assign sat_bus.id_wb_en = bus.id_wb_en;
  assign sat_bus.id_dest  = bus.id_dest;
  assign sat_bus.id_mem_r = bus.id_mem_r;
  assign sat_bus.FW_en    = bus.FW_en;
  assign sat_bus.freeze   = bus.freeze;
  assign sat_bus.flush    = bus.flush;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic wb, input logic [3:0] dest,
                        input logic memr);
    bus.id_valid = v;
    bus.src1     = s1;
    bus.src2     = s2;
    bus.two_src  = two;
    bus.id_wb_en = wb;
    bus.id_dest  = dest;
    bus.id_mem_r = memr;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_haz"}, {31'd0, bus.hazard}, 32'd0);
    check_val({tag, "_tags"}, {22'd0, bus.Dest_MEM, bus.WB_EN_MEM, bus.Dest_WB, bus.WB_EN_WB}, 32'd0);
    check_val({tag, "_cnt"}, {16'd0, bus.stall_count}, 32'd0);
  endtask

  initial begin
    idle();
    bus.FW_en  = 1'b1;
    bus.freeze = 1'b0;
    bus.flush  = 1'b0;

    // Reset, then idle for 10 cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check_all_zero("idle");
      tick();
    end

    // FW_en=1 load-use: LDR R3 then ADD R6 <- R3
    bus.FW_en = 1'b1;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
    settle();
    check_val("lu_first_haz", {31'd0, bus.hazard}, 32'd0);
    tick();
    set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
    settle();
    check_val("lu_haz", {31'd0, bus.hazard}, 32'd1);
    check_val("lu_cnt0", {16'd0, bus.stall_count}, 32'd0);
    tick();
    exp_cnt = 1;
    settle();
    check_val("lu_haz_gone", {31'd0, bus.hazard}, 32'd0);
    check_val("lu_mem_en", {31'd0, bus.WB_EN_MEM}, 32'd1);
    check_val("lu_mem_dest", {28'd0, bus.Dest_MEM}, 32'd3);
    check_val("lu_cnt1", {16'd0, bus.stall_count}, exp_cnt);
    tick();
    idle();
    settle();
    check_val("lu_wb_en", {31'd0, bus.WB_EN_WB}, 32'd1);
    check_val("lu_wb_dest", {28'd0, bus.Dest_WB}, 32'd3);
    check_val("lu_mem_bubble", {31'd0, bus.WB_EN_MEM}, 32'd0);
    tick();
    settle();
    check_val("lat_mem", {27'd0, bus.Dest_MEM, bus.WB_EN_MEM}, {27'd0, 4'd6, 1'b1});
    tick();
    settle();
    check_val("lat_wb", {27'd0, bus.Dest_WB, bus.WB_EN_WB}, {27'd0, 4'd6, 1'b1});
    drain();

    // FW_en=0, two_src=1: ADD R5 then SUB R7 <- R1, R5
    bus.FW_en = 1'b0;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
    tick();
    set_id(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 4'd7, 1'b0);
    settle();
    check_val("nofw_haz_exe", {31'd0, bus.hazard}, 32'd1);
    tick();
    settle();
    check_val("nofw_haz_mem", {31'd0, bus.hazard}, 32'd1);
    tick();
    exp_cnt = 3;
    settle();
    check_val("nofw_haz_wb", {31'd0, bus.hazard}, 32'd0);
    check_val("nofw_wb_tag", {27'd0, bus.Dest_WB, bus.WB_EN_WB}, {27'd0, 4'd5, 1'b1});
    check_val("nofw_cnt", {16'd0, bus.stall_count}, exp_cnt);
    drain();

    // Same pair with two_src=0: src2 must be ignored
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
    tick();
    set_id(1'b1, 4'd1, 4'd5, 1'b0, 1'b1, 4'd7, 1'b0);
    settle();
    check_val("one_src_exe", {31'd0, bus.hazard}, 32'd0);
    tick();
    settle();
    check_val("one_src_mem", {31'd0, bus.hazard}, 32'd0);
    tick();
    // R7 producers now sit in EXE and MEM; a bubble in ID must not stall
    set_id(1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    settle();
    check_val("bubble_no_haz", {31'd0, bus.hazard}, 32'd0);
    check_val("one_src_cnt", {16'd0, bus.stall_count}, exp_cnt);
    drain();

    // R15 producer, FW_en=0: two stall cycles
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0);
    tick();
    set_id(1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    settle();
    check_val("r15_haz1", {31'd0, bus.hazard}, 32'd1);
    tick();
    settle();
    check_val("r15_haz2", {31'd0, bus.hazard}, 32'd1);
    tick();
    exp_cnt = 5;
    settle();
    check_val("r15_haz3", {31'd0, bus.hazard}, 32'd0);
    check_val("r15_cnt", {16'd0, bus.stall_count}, exp_cnt);
    drain();

    // R0 producer (non-load): forwarding covers it, disabling forwarding exposes it
    bus.FW_en = 1'b1;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    settle();
    check_val("r0_fw_haz", {31'd0, bus.hazard}, 32'd0);
    bus.FW_en = 1'b0;
    #1;
    check_val("r0_nofw_haz", {31'd0, bus.hazard}, 32'd1);
    bus.FW_en = 1'b1;
    #1;
    idle();
    drain();

    // Load-use held by freeze for 3 cycles
    bus.FW_en = 1'b1;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1);
    tick();
    set_id(1'b1, 4'd4, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0);
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_val("frz_haz", {31'd0, bus.hazard}, 32'd1);
      check_val("frz_mem_hold", {31'd0, bus.WB_EN_MEM}, 32'd0);
      check_val("frz_cnt_hold", {16'd0, bus.stall_count}, exp_cnt);
      tick();
    end
    bus.freeze = 1'b0;
    settle();
    check_val("frz_haz_last", {31'd0, bus.hazard}, 32'd1);
    tick();
    exp_cnt = 6;
    settle();
    check_val("frz_haz_done", {31'd0, bus.hazard}, 32'd0);
    check_val("frz_mem_tag", {27'd0, bus.Dest_MEM, bus.WB_EN_MEM}, {27'd0, 4'd4, 1'b1});
    check_val("frz_cnt", {16'd0, bus.stall_count}, exp_cnt);
    drain();

    // Flush wins over a load-use hazard
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b1);
    tick();
    set_id(1'b1, 4'd8, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
    bus.flush = 1'b1;
    settle();
    check_val("flush_haz", {31'd0, bus.hazard}, 32'd0);
    tick();
    bus.flush = 1'b0;
    idle();
    settle();
    check_val("flush_mem_load", {27'd0, bus.Dest_MEM, bus.WB_EN_MEM}, {27'd0, 4'd8, 1'b1});
    check_val("flush_cnt", {16'd0, bus.stall_count}, exp_cnt);
    tick();
    settle();
    check_val("flush_mem_bubble", {31'd0, bus.WB_EN_MEM}, 32'd0);
    check_val("flush_wb_load", {27'd0, bus.Dest_WB, bus.WB_EN_WB}, {27'd0, 4'd8, 1'b1});
    drain();

    // Sustained self-dependent stream, FW_en=0: stall pattern 0,1,1 repeating
    check_val("pre_sat_cnt", {26'd0, sat_bus.stall_count}, exp_cnt);
    bus.FW_en = 1'b0;
    set_id(1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 105; i++) begin
      settle();
      check_val("stream_haz", {31'd0, bus.hazard}, (i % 3 != 0) ? 32'd1 : 32'd0);
      tick();
    end
    exp_cnt = 6 + 70;
    settle();
    check_val("stream_cnt", {16'd0, bus.stall_count}, exp_cnt);
    check_val("sat_cnt", {26'd0, sat_bus.stall_count}, 32'h3F);
    tick();
    settle();
    check_val("mid_stall_haz", {31'd0, bus.hazard}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check_all_zero("rst_mid");
    check_val("rst_mid_sat_cnt", {26'd0, sat_bus.stall_count}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
